// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the only arithmetic element in the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, one result bit per clock, LSB first, through a
// single full-adder cell. Subtraction is a + ~b + 1.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] work_shift;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_co;
    logic             accept, last_bit;

    fa_cell u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_w1
            assign work_shift = fa_s;
        end else begin : g_wn
            assign work_shift = {fa_s, work_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = a;
            b_d     = b ^ {WIDTH{sub}};
            carry_d = sub;
            cnt_d   = '0;
            work_d  = '0;
        end else if (state_q == ST_RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            work_d  = work_shift;
            carry_d = fa_co;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
                sum_d  = work_shift;
                cout_d = fa_co;
                ovf_d  = carry_q ^ fa_co;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 1..64).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request to begin an operation; sampled only in IDLE and DONE.
REQ-005 Port: a  input  WIDTH  first operand; sampled on the accepting edge only.
REQ-006 Port: b  input  WIDTH  second operand; sampled on the accepting edge only.
REQ-007 Port: sub  input  1  mode; 0 = a+b, 1 = a-b; sampled on the accepting edge only.
REQ-008 Port: busy  output  1  high while an operation is in progress (state RUN).
REQ-009 Port: done  output  1  single-cycle completion pulse.
REQ-010 Port: sum  output  WIDTH  result; registered, held between completions.
REQ-011 Port: cout  output  1  carry out of the MSB; for sub=1, 1 means no borrow.
REQ-012 Port: ovf  output  1  two's-complement signed overflow of the completed operation.

Function
REQ-013 The FSM shall have three states, IDLE, RUN and DONE, with IDLE as the reset state.
REQ-014 IDLE or DONE with start=1 at an edge: latch a, b^{WIDTH{sub}} and sub; carry flop <= sub; bit counter <= 0; next state RUN.
REQ-015 DONE with start=0 at an edge: next state IDLE.
REQ-016 RUN, each edge: one full-adder bit, LSB first; a-bit, b-bit and carry flop in; sum bit shifted into the working register; carry flop <= bit carry; counter +1.
REQ-017 RUN: on the edge processing bit WIDTH-1, sum <= working result, cout <= final carry, ovf <= carry-into-MSB XOR carry-out-of-MSB, next state DONE.
REQ-018 Latency: with start accepted at edge E0, done shall be high exactly from edge E_WIDTH to E_WIDTH+1.
REQ-019 done shall be high only in DONE, for exactly one cycle per accepted start.
REQ-020 busy shall be high in RUN only.
REQ-021 start while in RUN shall be ignored; the operation in flight shall be unaffected.
REQ-022 start in DONE shall be accepted (back-to-back); sum/cout/ovf hold the previous result until the new completion.
REQ-023 sum, cout and ovf shall not change except at the completion edge or reset.
REQ-024 The bit counter width shall be clog2(WIDTH)+1; for WIDTH=1, RUN shall last exactly one cycle.
REQ-025 Input changes on a, b or sub after the accepting edge shall have no effect on the result.

Reset
REQ-026 rst=1 shall immediately force state IDLE and zero busy, done, sum, cout, ovf, the carry flop, the counter and the working registers, with no clock required.
REQ-027 Reset during RUN shall abort the operation; no done pulse is produced for it.
REQ-028 After rst deasserts, the first start shall be accepted at the first rising edge that samples it high.

Structure
REQ-029 A shared package shall hold the state encoding (IDLE=0, RUN=1, DONE=2) and the default WIDTH constant.
REQ-030 The per-bit logic shall be a separate combinational sub-module fa_cell (a, b, cin -> s, co), instantiated once.
REQ-031 No arithmetic operator wider than one bit shall be used in the datapath; the add is carried out only through fa_cell.

Verification
REQ-032 WIDTH=8, a=0x7F, b=0x01, sub=0 -> done 8 cycles after start; sum=0x80, cout=0, ovf=1.
REQ-033 WIDTH=8, a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0.
REQ-034 WIDTH=8, a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0; then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-035 start pulsed at cycle 3 of RUN with different operands -> ignored; first result is unchanged; exactly one done pulse.
REQ-036 Second start held high in the DONE cycle -> second operation begins at once; its done arrives 8 cycles later; sum holds the first result until then.
REQ-037 rst asserted mid-RUN, between clock edges -> all outputs 0 at once; state IDLE; no done pulse; the next operation is correct.
